beat_gen: RTL
=============

Name: beat_gen

Overview:
- Parametrised CPU timing-beat generator: one-hot ring of NUM_BEATS beat strobes that sequences instruction micro-steps.
- Successor to the fixed 6-beat ring. Adds enable, stall, early end-of-cycle (variable-length instructions), single-step mode, halt-at-cycle-boundary, beat index and cycle counter.
- Sits between the clock source and the control unit; the control unit consumes beat and cycle_start.

Parameters:
- NUM_BEATS, 6, number of beats per full instruction cycle (>=2).
- IDX_W, $clog2(NUM_BEATS), width of beat_idx.
- CNT_W, 16, width of the instruction-cycle counter.

Ports:
- clk, input, 1, system clock; all logic on posedge.
- rst_n, input, 1, asynchronous active-low reset.
- run, input, 1, global enable; 0 freezes all state (except step edge detector).
- mode_step, input, 1, 1 = single-step mode: advance one beat per rising edge of step.
- step, input, 1, single-step request level (synchronous to clk).
- stall, input, 1, hold current beat (wait state).
- end_cycle, input, 1, sampled on an advance: next beat is beat 0 regardless of position.
- halt_req, input, 1, stop at next cycle boundary.
- beat, output, NUM_BEATS, one-hot beat strobe; bit k = t_k.
- beat_idx, output, IDX_W, binary index of the active beat.
- cycle_start, output, 1, one-clk pulse coincident with beat becoming t0.
- halted, output, 1, 1 while in HALTED state.
- cycle_cnt, output, CNT_W, count of completed wraps to t0.

Behaviour:
- Reset (async, rst_n=0):
  - beat = one-hot at bit NUM_BEATS-1; beat_idx = NUM_BEATS-1.
  - cycle_start = 0, halted = 0, cycle_cnt = 0, state = RUN, step edge register = 0.
  - The first advance after reset therefore produces t0 and a cycle_start pulse.
- Step edge detector: step_rise = step & ~step_q; step_q is updated every clk. A rise occurring while stall=1 or run=0 is discarded, not queued.
- Advance: adv = run & ~stall & (~mode_step | step_rise).
- Wrap: wrap = adv & (end_cycle | beat_idx == NUM_BEATS-1).
- State RUN:
  - adv & ~wrap: beat rotates left by one; beat_idx+1.
  - wrap & ~halt_req: beat = t0, beat_idx = 0, cycle_start = 1 for one clk, cycle_cnt += 1 (wraps modulo 2^CNT_W).
  - wrap & halt_req: beat/beat_idx hold, no cycle_start, no count; next state HALTED, halted = 1.
  - ~adv: everything holds; cycle_start = 0.
- State HALTED:
  - beat holds.
  - When halt_req = 0 and adv = 1: perform the wrap to t0 (cycle_start, count), state returns to RUN, halted = 0. Halt exit costs no extra beat.
- Boundary cases:
  - end_cycle at t0 with adv: stays t0, cycle_start pulses again (length-1 cycle).
  - end_cycle with no adv: ignored.
  - stall has priority over step and end_cycle.
  - mode_step toggled mid-cycle: takes effect on the next clk; beat position kept.
  - Mid-operation rst_n: immediate return to reset values, no glitch on beat beyond async clear.
- Invariant: beat is always exactly one-hot; beat_idx always equals the position of the set bit. Both are registered, never combinational from inputs.
- Latency: one clk from an adv condition to the new beat.

Decomposition:
- beat_pkg holds the state typedef (RUN, HALTED) and a function onehot_rotl.
- One natural sub-module: rise_detect (1-bit posedge detector, async active-low reset), instanced for step.

Test Plan:
- Reset then run=1, NUM_BEATS=6, all else 0 -> beat sequence t0..t5,t0 with beat_idx 0..5,0; cycle_start high exactly when beat=t0; cycle_cnt=2 after 12 clks.
- end_cycle=1 while beat=t2 -> next beat t0, cycle_start=1, cycle_cnt+1; end_cycle at t0 -> t0 repeats with second pulse.
- stall=1 for 3 clks at t3 -> beat holds t3 for 4 clks total, cycle_cnt unchanged; a step pulse during stall in step mode has no effect.
- mode_step=1, step toggled 0->1 held high 5 clks -> exactly one advance; three separate rising edges -> three advances.
- halt_req=1 at t4 -> advances to t5, then halted=1, beat stays t5 for 10 clks; halt_req=0 -> next clk t0, cycle_start=1, halted=0.
- CNT_W=4, run 16 cycles -> cycle_cnt wraps 15->0; rst_n pulsed low at t3 -> beat=t5, cycle_cnt=0 asynchronously.

Source files
------------

// File: rtl/beat_gen_pkg.sv
// Shared types and helpers for the beat generator: FSM state encoding and
// a width-agnostic one-hot left rotation.
package beat_gen_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  localparam int MAX_BEATS = 64;
  localparam logic [MAX_BEATS-1:0] ONE = MAX_BEATS'(1);

  // Rotates the low n bits of v left by one; bits at n and above come back zero.
  function automatic logic [MAX_BEATS-1:0] onehot_rotl(input logic [MAX_BEATS-1:0] v,
                                                       input int n);
    logic [MAX_BEATS-1:0] top;
    logic [MAX_BEATS-1:0] mask;
    logic [MAX_BEATS-1:0] r;
    top  = ONE << (n - 1);
    mask = (top << 1) - ONE;
    r    = (v << 1) & mask;
    r[0] = |(v & top);
    return r;
  endfunction

endpackage

// File: rtl/beat_gen_if.sv
// Control/status bundle between the beat generator and its controller.
interface beat_gen_if #(
  parameter int NUM_BEATS = 6,
  parameter int IDX_W     = $clog2(NUM_BEATS),
  parameter int CNT_W     = 16
);
  logic                 run;
  logic                 mode_step;
  logic                 step;
  logic                 stall;
  logic                 end_cycle;
  logic                 halt_req;
  logic [NUM_BEATS-1:0] beat;
  logic [IDX_W-1:0]     beat_idx;
  logic                 cycle_start;
  logic                 halted;
  logic [CNT_W-1:0]     cycle_cnt;

  modport master (
    output run, mode_step, step, stall, end_cycle, halt_req,
    input  beat, beat_idx, cycle_start, halted, cycle_cnt
  );

  modport slave (
    input  run, mode_step, step, stall, end_cycle, halt_req,
    output beat, beat_idx, cycle_start, halted, cycle_cnt
  );
endinterface

// File: rtl/beat_gen_rise_detect.sv
// Single-bit rising-edge detector; the history register updates every clock.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign rise = d & ~d_q;
endmodule

// File: rtl/beat_gen.sv
// One-hot timing-beat ring with stall, early end-of-cycle, single-step,
// halt-at-boundary, beat index and completed-cycle counter.
import beat_gen_pkg::*;

module beat_gen #(
  parameter int NUM_BEATS = 6,
  parameter int IDX_W     = $clog2(NUM_BEATS),
  parameter int CNT_W     = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  beat_gen_if.slave bus
);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_BEATS - 1);
  localparam logic [NUM_BEATS-1:0] T0       = NUM_BEATS'(1);
  localparam logic [NUM_BEATS-1:0] TLAST    = {1'b1, {(NUM_BEATS-1){1'b0}}};

  state_t               state_p0, state_d;
  logic [NUM_BEATS-1:0] beat_p0, beat_d;
  logic [IDX_W-1:0]     idx_p0, idx_d;
  logic [CNT_W-1:0]     cnt_p0, cnt_d;
  logic                 cs_p0, cs_d;
  logic                 step_rise;
  logic                 adv;
  logic                 wrap;

  rise_detect u_step_rise (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (bus.step),
    .rise (step_rise)
  );

  // A step edge that lands during stall or run=0 is consumed here and lost.
  assign adv  = bus.run & ~bus.stall & (~bus.mode_step | step_rise);
  assign wrap = adv & (bus.end_cycle | (idx_p0 == LAST_IDX));

  always_comb begin
    state_d = state_p0;
    beat_d  = beat_p0;
    idx_d   = idx_p0;
    cnt_d   = cnt_p0;
    cs_d    = 1'b0;
    unique case (state_p0)
      RUN: begin
        if (wrap) begin
          if (bus.halt_req) begin
            state_d = HALTED;
          end else begin
            beat_d = T0;
            idx_d  = '0;
            cs_d   = 1'b1;
            cnt_d  = cnt_p0 + CNT_W'(1);
          end
        end else if (adv) begin
          beat_d = NUM_BEATS'(onehot_rotl(MAX_BEATS'(beat_p0), NUM_BEATS));
          idx_d  = idx_p0 + IDX_W'(1);
        end
      end
      HALTED: begin
        // Leaving halt performs the pending wrap directly, with no dead beat.
        if (adv && !bus.halt_req) begin
          state_d = RUN;
          beat_d  = T0;
          idx_d   = '0;
          cs_d    = 1'b1;
          cnt_d   = cnt_p0 + CNT_W'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Stage p0: registered beat ring, index, counter and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= RUN;
      beat_p0  <= TLAST;
      idx_p0   <= LAST_IDX;
      cnt_p0   <= '0;
      cs_p0    <= 1'b0;
    end else begin
      state_p0 <= state_d;
      beat_p0  <= beat_d;
      idx_p0   <= idx_d;
      cnt_p0   <= cnt_d;
      cs_p0    <= cs_d;
    end
  end

  assign bus.beat        = beat_p0;
  assign bus.beat_idx    = idx_p0;
  assign bus.cycle_start = cs_p0;
  assign bus.halted      = (state_p0 == HALTED);
  assign bus.cycle_cnt   = cnt_p0;
endmodule
